// File: rtl/ifu_pkg.sv
// Shared constants and decode helpers for the IFU prefetch buffer.
// IFU_RVC_EN selects compressed-instruction support.
package ifu_pkg;

    localparam int FETCH_W_MIN = 32;
    localparam int FETCH_W_MAX = 64;

`ifdef IFU_RVC_EN
    localparam bit RVC_EN = 1'b1;
`else
    localparam bit RVC_EN = 1'b0;
`endif

    function automatic int hw_per_word(input int fetch_w);
        return fetch_w / 16;
    endfunction

    // Encodings with low bits 2'b11 are 32-bit; longer forms are treated as 32-bit too
    function automatic logic is_len32(input logic [1:0] lo_bits);
        return (lo_bits == 2'b11);
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Fetched-word FIFO holding each word with its address; supports one push
// and up to two pops per cycle plus a synchronous clear.
module ifu_fetch_fifo
    import ifu_pkg::*;
#(
    parameter int FETCH_W = 32,
    parameter int PC_SIZE = 32,
    parameter int DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         push,
    input  logic [FETCH_W-1:0]           push_data,
    input  logic [PC_SIZE-1:0]           push_addr,
    input  logic                         pop0,
    input  logic                         pop1,
    output logic [FETCH_W-1:0]           head_data,
    output logic [PC_SIZE-1:0]           head_addr,
    output logic [15:0]                  next_hw,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [FETCH_W-1:0] data_r [DEPTH];
    logic [PC_SIZE-1:0] addr_r [DEPTH];
    logic [AW-1:0]      wr_ptr_r;
    logic [AW-1:0]      rd_ptr_r;
    logic [AW-1:0]      rd_nxt_s;
    logic [CW-1:0]      count_r;
    logic [1:0]         npop_s;

    // Number of entries leaving this cycle; pop1 is only meaningful with pop0
    always_comb begin
        rd_nxt_s = rd_ptr_r + AW'(1);
        if (pop1) begin
            npop_s = 2'd2;
        end else if (pop0) begin
            npop_s = 2'd1;
        end else begin
            npop_s = 2'd0;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_r + AW'(npop_s);
            count_r  <= count_r + CW'(push) - CW'(npop_s);
        end
    end

    // Entry storage
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            data_r[wr_ptr_r] <= push_data;
            addr_r[wr_ptr_r] <= push_addr;
        end
    end

    assign head_data = data_r[rd_ptr_r];
    assign head_addr = addr_r[rd_ptr_r];
    assign next_hw   = data_r[rd_nxt_s][15:0];
    assign count     = count_r;

endmodule

// File: rtl/ifu_prefetch_buf_chk.sv
// Simulation checks on the prefetch buffer credit scheme.
module ifu_prefetch_buf_chk (
    input logic clk,
    input logic rst_n,
    input logic push,
    input logic fifo_full,
    input logic rsp_valid,
    input logic outst_zero
);

    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));
    a_no_rsp_idle:  assert property (@(posedge clk) disable iff (!rst_n) !(rsp_valid && outst_zero));

endmodule

// File: rtl/ifu_prefetch_buf.sv
// Instruction prefetch buffer: credit-based multi-outstanding fetch, word FIFO
// and halfword realigner. IFU_RVC_EN enables 16-bit instruction support.
module ifu_prefetch_buf
    import ifu_pkg::*;
#(
    parameter int                 PC_SIZE  = 32,
    parameter int                 FETCH_W  = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [PC_SIZE-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [PC_SIZE-1:0] mem_req_addr,
    input  logic               mem_rsp_valid,
    input  logic [FETCH_W-1:0] mem_rsp_data,
    input  logic               flush_req,
    input  logic [PC_SIZE-1:0] flush_pc,
    output logic               ifu_o_valid,
    input  logic               ifu_i_ready,
    output logic [31:0]        ifu_o_ir,
    output logic [PC_SIZE-1:0] ifu_o_pc,
    output logic               ifu_o_len16
);

    localparam int HW    = hw_per_word(FETCH_W);
    localparam int HPW   = $clog2(HW);
    localparam int PW    = HPW + 2;
    localparam int BYTES = FETCH_W / 8;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int CW1   = CW + 1;
    localparam int XW    = $clog2(FETCH_W + 16);

    // Without RVC the realigner only ever sits on 32-bit lane boundaries
    localparam logic [HPW-1:0]     LANE_MASK = RVC_EN ? {HPW{1'b1}} : ~HPW'(1'b1);
    localparam logic [PC_SIZE-1:0] BASE_MASK = ~PC_SIZE'(BYTES - 1);
    localparam logic [PC_SIZE-1:0] RST_BASE  = RESET_PC & BASE_MASK;
    localparam logic [HPW-1:0]     RST_HW    = RESET_PC[$clog2(BYTES)-1:1] & LANE_MASK;

    logic [PC_SIZE-1:0] fetch_addr_r, head_base_r, tail_addr_r;
    logic [HPW-1:0]     hw_ptr_r;
    logic [CW-1:0]      outst_r, discard_r, count_s;
    logic [FETCH_W-1:0] head_data_s;
    logic [PC_SIZE-1:0] head_addr_s, flush_base_s;
    logic [HPW-1:0]     flush_hw_s;
    logic [15:0]        next_hw_s;
    logic [FETCH_W+15:0] ext_s;
    logic [XW-1:0]      idx_s;
    logic [31:0]        ir32_s, ir_s;
    logic [PW-1:0]      ptr_sum_s;
    logic               req_valid_s, req_fire_s, push_s, pop0_s, pop1_s;
    logic               len32_s, straddle_s, avail_s, valid_s, fire_s;

    // Request credit and response acceptance
    always_comb begin
        flush_base_s = flush_pc & BASE_MASK;
        flush_hw_s   = flush_pc[$clog2(BYTES)-1:1] & LANE_MASK;
        req_valid_s  = rst_n && !flush_req &&
                       (({1'b0, count_s} + {1'b0, outst_r}) < CW1'(DEPTH));
        req_fire_s   = req_valid_s && mem_req_ready;
        push_s       = mem_rsp_valid && (discard_r == '0) && !flush_req;
    end

    // Realigner: extract the instruction at hw_ptr, borrowing from the next word when it straddles
    always_comb begin
        ext_s  = {next_hw_s, head_data_s};
        idx_s  = XW'({hw_ptr_r, 4'b0000});
        ir32_s = ext_s[idx_s +: 32];
`ifdef IFU_RVC_EN
        len32_s = is_len32(ir32_s[1:0]);
`else
        len32_s = 1'b1;
`endif
        straddle_s = len32_s && (hw_ptr_r == HPW'(HW - 1));
        avail_s    = straddle_s ? (count_s >= CW'(2)) : (count_s != '0);
        valid_s    = avail_s && !flush_req;
        if (!valid_s) begin
            ir_s = 32'h0000_0000;
        end else if (len32_s) begin
            ir_s = ir32_s;
        end else begin
            ir_s = {16'h0000, ir32_s[15:0]};
        end
        fire_s    = valid_s && ifu_i_ready;
        ptr_sum_s = PW'(hw_ptr_r) + (len32_s ? PW'(2) : PW'(1));
        pop0_s    = fire_s && (ptr_sum_s[PW-1:HPW] != 2'b00);
        pop1_s    = fire_s && ptr_sum_s[PW-1];
    end

    // Fetch pointer, realigner position and outstanding/discard credits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_addr_r <= RST_BASE;
            head_base_r  <= RST_BASE;
            tail_addr_r  <= RST_BASE;
            hw_ptr_r     <= RST_HW;
            outst_r      <= '0;
            discard_r    <= '0;
        end else if (flush_req) begin
            fetch_addr_r <= flush_base_s;
            head_base_r  <= flush_base_s;
            tail_addr_r  <= flush_base_s;
            hw_ptr_r     <= flush_hw_s;
            outst_r      <= outst_r - CW'(mem_rsp_valid);
            discard_r    <= outst_r - CW'(mem_rsp_valid);
        end else begin
            if (req_fire_s) begin
                fetch_addr_r <= fetch_addr_r + PC_SIZE'(BYTES);
            end
            if (push_s) begin
                tail_addr_r <= tail_addr_r + PC_SIZE'(BYTES);
            end
            if (fire_s) begin
                hw_ptr_r <= ptr_sum_s[HPW-1:0];
            end
            if (pop0_s) begin
                head_base_r <= head_base_r + (pop1_s ? PC_SIZE'(2 * BYTES) : PC_SIZE'(BYTES));
            end
            outst_r <= outst_r + CW'(req_fire_s) - CW'(mem_rsp_valid);
            if (mem_rsp_valid && (discard_r != '0)) begin
                discard_r <= discard_r - CW'(1);
            end
        end
    end

    ifu_fetch_fifo #(
        .FETCH_W (FETCH_W),
        .PC_SIZE (PC_SIZE),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush_req),
        .push      (push_s),
        .push_data (mem_rsp_data),
        .push_addr (tail_addr_r),
        .pop0      (pop0_s),
        .pop1      (pop1_s),
        .head_data (head_data_s),
        .head_addr (head_addr_s),
        .next_hw   (next_hw_s),
        .count     (count_s)
    );

    ifu_prefetch_buf_chk u_chk (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .fifo_full  (count_s == CW'(DEPTH)),
        .rsp_valid  (mem_rsp_valid),
        .outst_zero (outst_r == '0)
    );

    assign mem_req_valid = req_valid_s;
    assign mem_req_addr  = fetch_addr_r;
    assign ifu_o_valid   = valid_s;
    assign ifu_o_ir      = ir_s;
    assign ifu_o_len16   = valid_s && !len32_s;
    assign ifu_o_pc      = ((count_s != '0) ? head_addr_s : head_base_r) + PC_SIZE'({hw_ptr_r, 1'b0});

endmodule

// File: tb/tb_ifu_prefetch_buf.sv
// Directed bench for ifu_prefetch_buf with a fixed-latency in-order memory model.
`timescale 1ns/1ps
module tb_ifu_prefetch_buf;
`ifdef IFU_RVC_EN
    localparam int FW = 32;
`else
    localparam int FW = 64;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b1;
    logic [31:0]   mem_req_addr;
    logic          mem_rsp_valid;
    logic [FW-1:0] mem_rsp_data;
    logic          flush_req = 1'b0;
    logic [31:0]   flush_pc = 32'h0;
    logic          ifu_o_valid;
    logic          ifu_i_ready = 1'b0;
    logic [31:0]   ifu_o_ir;
    logic [31:0]   ifu_o_pc;
    logic          ifu_o_len16;

    int total = 0;
    int bad = 0;
    int lat = 1;
    int cyc = 0;
    int req_cnt = 0;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t pend_q[$];

    always #5 clk = ~clk;

    ifu_prefetch_buf #(.PC_SIZE(32), .FETCH_W(FW), .DEPTH(4), .RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
        .flush_req(flush_req), .flush_pc(flush_pc),
        .ifu_o_valid(ifu_o_valid), .ifu_i_ready(ifu_i_ready), .ifu_o_ir(ifu_o_ir),
        .ifu_o_pc(ifu_o_pc), .ifu_o_len16(ifu_o_len16)
    );

    function automatic logic [31:0] mem32(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem32 = 32'h0000_0013;
            32'h0000_0004: mem32 = 32'h0000_0093;
            32'h0000_0200: mem32 = 32'h0001_4501;
            32'h0000_0204: mem32 = 32'h0000_0093;
            32'h0000_0300: mem32 = 32'h0513_0000;
            32'h0000_0304: mem32 = 32'h0000_0000;
            default: begin
                if (a >= 32'h0000_0100 && a < 32'h0000_0180) mem32 = 32'h0000_0013;
                else mem32 = {a[23:0], 8'h33};
            end
        endcase
    endfunction

    function automatic logic [FW-1:0] memw(input logic [31:0] a);
        logic [63:0] w;
        w = {mem32(a + 32'd4), mem32(a)};
        return w[FW-1:0];
    endfunction

    // In-order memory: response visible lat cycles after the request handshake
    always @(posedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            mem_rsp_valid <= 1'b0;
            mem_rsp_data  <= '0;
        end else begin
            if (mem_req_valid && mem_req_ready) begin
                pend_q.push_back('{mem_req_addr, cyc + lat});
                req_cnt <= req_cnt + 1;
            end
            if (pend_q.size() > 0 && pend_q[0].due <= cyc + 1) begin
                mem_rsp_valid <= 1'b1;
                mem_rsp_data  <= memw(pend_q[0].addr);
                pend_q.pop_front();
            end else begin
                mem_rsp_valid <= 1'b0;
            end
        end
        cyc <= cyc + 1;
    end

    task automatic take(input logic [31:0] epc, input logic [31:0] eir, input logic elen, input string nm);
        bit got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (ifu_o_valid === 1'b1) got = 1'b1;
        end
        total++;
        if (!got) begin
            bad++;
            $display("FAIL %s: ifu_o_valid never rose, wanted pc=%h", nm, epc);
        end else if (ifu_o_pc !== epc || ifu_o_ir !== eir || ifu_o_len16 !== elen) begin
            bad++;
            $display("FAIL %s: got pc=%h ir=%h len16=%b, wanted pc=%h ir=%h len16=%b",
                     nm, ifu_o_pc, ifu_o_ir, ifu_o_len16, epc, eir, elen);
        end
        ifu_i_ready = got;
    endtask

    task automatic do_flush(input logic [31:0] pc);
        @(negedge clk);
        ifu_i_ready = 1'b0;
        flush_req = 1'b1;
        flush_pc = pc;
        #1;
        total++;
        if (mem_req_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_req: mem_req_valid=%b, wanted 0", mem_req_valid);
        end
        total++;
        if (ifu_o_valid !== 1'b0) begin
            bad++;
            $display("FAIL flush_no_valid: ifu_o_valid=%b, wanted 0", ifu_o_valid);
        end
        @(negedge clk);
        flush_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (mem_req_valid !== 1'b0) begin bad++; $display("FAIL rst_req: got %b wanted 0", mem_req_valid); end
        total++; if (ifu_o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b wanted 0", ifu_o_valid); end
        total++; if (ifu_o_ir !== 32'h0) begin bad++; $display("FAIL rst_ir: got %h wanted 0", ifu_o_ir); end
        total++; if (ifu_o_pc !== 32'h100) begin bad++; $display("FAIL rst_pc: got %h wanted 100", ifu_o_pc); end
        total++; if (ifu_o_len16 !== 1'b0) begin bad++; $display("FAIL rst_len16: got %b wanted 0", ifu_o_len16); end
        rst_n = 1'b1;
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin
            bad++;
            $display("FAIL first_req: got valid=%b addr=%h wanted 1 100", mem_req_valid, mem_req_addr);
        end
        take(32'h100, 32'h13, 1'b0, "nop0");
        take(32'h104, 32'h13, 1'b0, "nop1");
        take(32'h108, 32'h13, 1'b0, "nop2");
    endtask

`ifndef IFU_RVC_EN
    task automatic test_wide_word();
        do_flush(32'h0);
        take(32'h0, 32'h13, 1'b0, "w64_lo");
        take(32'h4, 32'h93, 1'b0, "w64_hi");
        take(32'h8, 32'h833, 1'b0, "w64_next");
        do_flush(32'h6);
        take(32'h4, 32'h93, 1'b0, "bit1_ignored");
    endtask
`else
    task automatic test_rvc_mixed();
        do_flush(32'h200);
        take(32'h200, 32'h4501, 1'b1, "rvc_a");
        take(32'h202, 32'h0001, 1'b1, "rvc_b");
        take(32'h204, 32'h93, 1'b0, "rvc_c");
    endtask

    task automatic test_straddle();
        bit seen = 1'b0;
        mem_req_ready = 1'b0;
        do_flush(32'h302);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (ifu_o_valid !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin bad++; $display("FAIL straddle_wait: valid seen=%b with one word, wanted 0", seen); end
        mem_req_ready = 1'b1;
        take(32'h302, 32'h0000_0513, 1'b0, "straddle");
    endtask
`endif

    task automatic test_flush_outstanding();
        lat = 4;
        do_flush(32'h300);
        repeat (3) @(negedge clk);
        do_flush(32'h400);
        #1;
        total++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h400) begin
            bad++;
            $display("FAIL post_flush_req: got valid=%b addr=%h wanted 1 400", mem_req_valid, mem_req_addr);
        end
        for (int i = 0; i < 4; i++) take(32'h400 + 4 * i, mem32(32'h400 + 4 * i), 1'b0, "flush_drop");
        lat = 1;
    endtask

    task automatic test_backpressure();
        int base;
        do_flush(32'h500);
        base = req_cnt;
        repeat (20) @(negedge clk);
        total++;
        if (req_cnt - base !== 4) begin bad++; $display("FAIL bp_reqs: got %0d wanted 4", req_cnt - base); end
        total++;
        if (ifu_o_valid !== 1'b1 || ifu_o_pc !== 32'h500 || ifu_o_ir !== mem32(32'h500)) begin
            bad++;
            $display("FAIL bp_hold: got v=%b pc=%h ir=%h wanted 1 500 %h", ifu_o_valid, ifu_o_pc, ifu_o_ir, mem32(32'h500));
        end
        for (int i = 0; i < 6; i++) take(32'h500 + 4 * i, mem32(32'h500 + 4 * i), 1'b0, "bp_drain");
    endtask

    task automatic test_back_to_back();
        lat = 4;
        do_flush(32'h600);
        repeat (2) @(negedge clk);
        @(negedge clk);
        flush_req = 1'b1;
        flush_pc = 32'h6A0;
        @(negedge clk);
        flush_pc = 32'h700;
        @(negedge clk);
        flush_req = 1'b0;
        for (int i = 0; i < 4; i++) take(32'h700 + 4 * i, mem32(32'h700 + 4 * i), 1'b0, "b2b_flush");
        lat = 1;
    endtask

    initial begin
        test_reset();
`ifndef IFU_RVC_EN
        test_wide_word();
`else
        test_rvc_mixed();
        test_straddle();
`endif
        test_flush_outstanding();
        test_backpressure();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
